// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array output path: memory geometry and
// the result-drain sequencer state encoding.
package systolic_pkg;

  localparam int OUT_ADDR_W = 7;
  localparam int OUT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with occupancy count and registered head, used as the skid
// buffer between a latency-1 memory read and a valid/ready stream.
module skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= {DATA_W{1'b0}};
      r_mem[1] <= {DATA_W{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/result_drain.sv
// Sweeps the systolic-array output memory after ap_done rises and streams the
// words to the host over valid/ready, with m_last on the final word.
module result_drain
  import systolic_pkg::*;
#(
  parameter int ADDR_W = OUT_ADDR_W,
  parameter int DATA_W = OUT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_done,
  input  logic [ADDR_W:0]   drain_len,
  output logic [ADDR_W-1:0] addrO,
  input  logic [DATA_W-1:0] dataO,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              drain_done
);

  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("result_drain supports RD_LAT = 1 only");
  end

  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  drain_state_t      r_state;
  drain_state_t      w_next;
  logic              r_ap_done_q;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_beats_left;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_busy;
  logic              r_drain_done;

  logic              w_trig;
  logic              w_start;
  logic              w_issue;
  logic              w_room;
  logic              w_pop;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_head;

  assign w_trig  = ap_done & ~r_ap_done_q;
  assign m_valid = (w_count != 2'd0);
  assign w_pop   = m_valid & m_ready;
  // A slot being popped this cycle counts as free, so one read per cycle is sustained.
  assign w_room  = (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd2) | w_pop;

  // Next-state, read issue and read address; the first read goes out in the trigger cycle.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_issue = 1'b0;
    w_addr  = r_addr_q;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          if (drain_len != LEN_ZERO) begin
            w_start = 1'b1;
            w_issue = 1'b1;
            w_addr  = {ADDR_W{1'b0}};
            w_next  = (drain_len == LEN_ONE) ? ST_FLUSH : ST_ISSUE;
          end else begin
            w_next = ST_FIN;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_room) begin
          w_issue = 1'b1;
          w_addr  = r_rd_ptr[ADDR_W-1:0];
          w_next  = (r_rd_ptr == (r_len - LEN_ONE)) ? ST_FLUSH : ST_ISSUE;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if ((r_beats_left == LEN_ZERO) || ((r_beats_left == LEN_ONE) && w_pop)) begin
          w_next = ST_FIN;
        end else begin
          w_next = ST_FLUSH;
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register, drain bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_ap_done_q  <= 1'b0;
      r_len        <= LEN_ZERO;
      r_rd_ptr     <= LEN_ZERO;
      r_beats_left <= LEN_ZERO;
      r_inflight   <= 1'b0;
      r_addr_q     <= {ADDR_W{1'b0}};
      r_busy       <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ap_done_q <= ap_done;
      r_inflight  <= w_issue;
      r_addr_q    <= w_addr;
      if (w_start) begin
        r_len        <= drain_len;
        r_rd_ptr     <= LEN_ONE;
        r_beats_left <= drain_len;
      end else begin
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + LEN_ONE;
        end
        if (w_pop && (r_beats_left != LEN_ZERO)) begin
          r_beats_left <= r_beats_left - LEN_ONE;
        end
      end
      r_busy       <= (w_next == ST_ISSUE) || (w_next == ST_FLUSH);
      r_drain_done <= (w_next == ST_FIN);
    end
  end

  skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_inflight),
    .i_data  (dataO),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign addrO      = w_addr;
  assign m_data     = w_head;
  assign m_last     = m_valid & (r_beats_left == LEN_ONE);
  assign busy       = r_busy;
  assign drain_done = r_drain_done;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a latency-1 output memory model, a scoreboard
// of expected beats and a negedge monitor that checks every transferred word.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        ap_done;
  logic [7:0]  drain_len;
  logic [6:0]  addrO;
  logic [31:0] dataO;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        drain_done;

  logic [31:0] mem [128];
  logic [32:0] sb [$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int test_id = 0;
  int rmode = 0;

  int mon_id = 0;
  int n_beats = 0;
  int n_done = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  int max_addr = 0;
  int zero_mid = 0;
  bit saw_busy = 1'b0;
  bit saw_valid = 1'b0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic prev_last = 1'b0;

  result_drain dut (
    .clk        (clk),
    .rst        (rst),
    .ap_done    (ap_done),
    .drain_len  (drain_len),
    .addrO      (addrO),
    .dataO      (dataO),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) dataO <= mem[addrO];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard compare on each transfer, stall stability, per-test trackers.
  always @(negedge clk) begin
    logic [32:0] e;
    if (test_id != mon_id) begin
      mon_id = test_id; n_beats = 0; n_done = 0; first_cyc = -1; last_cyc = -1;
      done_cyc = -1; max_addr = 0; zero_mid = 0; saw_busy = 1'b0; saw_valid = 1'b0;
    end
    if (!rst) begin
      prev_stall = 1'b0;
      sb.delete();
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        if (n_beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_beats++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", m_data, e[31:0]);
          chk("beat_last", m_last, e[32]);
        end
      end
      if (drain_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (busy) saw_busy = 1'b1;
      if (m_valid) saw_valid = 1'b1;
      if (int'(addrO) > max_addr) max_addr = int'(addrO);
      if (busy && n_beats > 0 && addrO == 7'd0) zero_mid++;
    end
  end

  // Host ready: constant 1, or the repeating 1,0,0 pattern.
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode != 0) begin
        m_ready = ((k % 3) == 0);
        k++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic start_test(input int id);
    @(posedge clk);
    #1;
    test_id = id;
    @(negedge clk);
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    ap_done  = 1'b1;
    trig_cyc = cyc;
    @(posedge clk);
    #1;
    ap_done = 1'b0;
  endtask

  task automatic load_sb(input int len);
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), mem[i]});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk(tag, (n_done != 0), 1'b1);
  endtask

  initial begin
    int t;
    rst = 1'b0;
    ap_done = 1'b0;
    drain_len = 8'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addrO", addrO, 7'd0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    rst = 1'b1;

    // Four words, host always ready.
    start_test(1);
    rmode = 0; drain_len = 8'd4; load_sb(4);
    pulse();
    wait_done(40, "t1_timeout");
    repeat (3) @(posedge clk);
    chk("t1_beats", n_beats, 4);
    chk("t1_first_latency", first_cyc - trig_cyc, 2);
    chk("t1_back_to_back", last_cyc - first_cyc, 3);
    chk("t1_done_after_last", done_cyc - last_cyc, 1);
    chk("t1_done_count", n_done, 1);
    chk("t1_sb_left", sb.size(), 0);

    // Same words with the host stalling.
    start_test(2);
    rmode = 1; drain_len = 8'd4; load_sb(4);
    pulse();
    wait_done(80, "t2_timeout");
    repeat (3) @(posedge clk);
    chk("t2_beats", n_beats, 4);
    chk("t2_max_addr", max_addr, 3);
    chk("t2_done_count", n_done, 1);
    chk("t2_sb_left", sb.size(), 0);

    // Zero-length drain.
    start_test(3);
    rmode = 0; drain_len = 8'd0;
    pulse();
    wait_done(20, "t3_timeout");
    repeat (3) @(posedge clk);
    chk("t3_done_count", n_done, 1);
    chk("t3_done_latency", done_cyc - trig_cyc, 1);
    chk("t3_no_valid", saw_valid, 1'b0);
    chk("t3_no_busy", saw_busy, 1'b0);

    // Full 128-word sweep.
    start_test(4);
    for (int i = 0; i < 128; i++) mem[i] = i;
    drain_len = 8'd128; load_sb(128);
    pulse();
    wait_done(300, "t4_timeout");
    repeat (3) @(posedge clk);
    chk("t4_beats", n_beats, 128);
    chk("t4_max_addr", max_addr, 127);
    chk("t4_no_early_wrap", zero_mid, 0);
    chk("t4_done_count", n_done, 1);

    // ap_done held high: one drain only.
    start_test(5);
    drain_len = 8'd4; load_sb(4);
    @(posedge clk);
    #1;
    ap_done = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    ap_done = 1'b0;
    repeat (10) @(posedge clk);
    chk("t5_beats", n_beats, 4);
    chk("t5_done_count", n_done, 1);

    // Second trigger while busy is ignored.
    start_test(6);
    rmode = 1; drain_len = 8'd8; load_sb(8);
    pulse();
    repeat (4) @(posedge clk);
    #1;
    chk("t6_busy", busy, 1'b1);
    drain_len = 8'd3;
    pulse();
    wait_done(100, "t6_timeout");
    repeat (20) @(posedge clk);
    chk("t6_beats", n_beats, 8);
    chk("t6_done_count", n_done, 1);
    chk("t6_sb_left", sb.size(), 0);

    // Reset part-way through an 8-word drain.
    start_test(7);
    rmode = 0; drain_len = 8'd8; load_sb(8);
    pulse();
    t = 0;
    while (n_beats < 2 && t < 20) begin
      @(posedge clk);
      t++;
    end
    chk("t7_two_beats", (n_beats >= 2), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_addrO", addrO, 7'd0);
    chk("t7_rst_m_valid", m_valid, 1'b0);
    chk("t7_rst_m_data", m_data, 32'd0);
    chk("t7_rst_m_last", m_last, 1'b0);
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_drain_done", drain_done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    chk("t7_no_done", n_done, 0);

    // Fresh drain after reset starts at address 0.
    start_test(8);
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
    drain_len = 8'd8; load_sb(8);
    pulse();
    wait_done(40, "t8_timeout");
    repeat (3) @(posedge clk);
    chk("t8_beats", n_beats, 8);
    chk("t8_first_latency", first_cyc - trig_cyc, 2);
    chk("t8_done_count", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
